// File: rtl/evalpos_pkg.sv
// Shared types and default widths for the evalPos dot-product stage.
package evalpos_pkg;

  localparam int unsigned DACC_DIN0_W = 6;
  localparam int unsigned DACC_DIN1_W = 8;
  localparam int unsigned DACC_PROD_W = 13;
  localparam int unsigned DACC_LEN_W  = 8;
  localparam int unsigned DACC_ACC_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dacc_state_t;

endpackage

// File: rtl/evalpos_mul_u6u8.sv
// Combinational unsigned multiplier; product truncated to PROD_W low bits.
module evalpos_mul_u6u8
  import evalpos_pkg::*;
#(
  parameter int unsigned DIN0_W = DACC_DIN0_W,
  parameter int unsigned DIN1_W = DACC_DIN1_W,
  parameter int unsigned PROD_W = DACC_PROD_W
) (
  input  logic [DIN0_W-1:0] a,
  input  logic [DIN1_W-1:0] b,
  output logic [PROD_W-1:0] prod_c
);

  localparam int unsigned FULL_W = DIN0_W + DIN1_W;

  logic [FULL_W-1:0] full_c;

  assign full_c = FULL_W'(a) * FULL_W'(b);
  assign prod_c = full_c[PROD_W-1:0];

endmodule

// File: rtl/evalpos_dot_acc.sv
// Pipelined dot-product stage: counted operand stream -> multiply -> accumulate,
// one result per job presented on a valid/ready output.
module evalpos_dot_acc
  import evalpos_pkg::*;
#(
  parameter int unsigned DIN0_W = DACC_DIN0_W,
  parameter int unsigned DIN1_W = DACC_DIN1_W,
  parameter int unsigned PROD_W = DACC_PROD_W,
  parameter int unsigned LEN_W  = DACC_LEN_W,
  parameter int unsigned ACC_W  = DACC_ACC_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN0_W-1:0] in_a,
  input  logic [DIN1_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  dacc_state_t state, state_nxt;

  logic [LEN_W-1:0]  remain;
  logic              drain_entry;
  logic              s1_v;
  logic [DIN0_W-1:0] s1_a;
  logic [DIN1_W-1:0] s1_b;
  logic              s2_v;
  logic [PROD_W-1:0] s2_prod;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [ACC_W:0]    sum_c;
  logic              start_c;
  logic              accept_c;

  assign start_c  = ap_start && (state == ST_IDLE);
  assign accept_c = in_valid && in_ready;
  assign sum_c    = (ACC_W+1)'(acc) + (ACC_W+1)'(s2_prod);

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; DRAIN always dwells at least two cycles so an empty job
  // and the pipeline tail see the same result timing.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_c) state_nxt = (cfg_len == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (accept_c && remain == LEN_W'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_v && !s2_v && !drain_entry) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    ap_idle   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE:  ap_idle   = 1'b1;
      ST_RUN:   in_ready  = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Job control: remaining-term counter, drain dwell flag, done pulse
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      remain      <= '0;
      drain_entry <= 1'b0;
      ap_done     <= 1'b0;
    end else begin
      if (start_c)       remain <= cfg_len;
      else if (accept_c) remain <= remain - LEN_W'(1);
      drain_entry <= (state != ST_DRAIN) && (state_nxt == ST_DRAIN);
      ap_done     <= (state == ST_DONE) && out_ready;
    end
  end

  evalpos_mul_u6u8 #(
    .DIN0_W (DIN0_W),
    .DIN1_W (DIN1_W),
    .PROD_W (PROD_W)
  ) u_mul (
    .a      (s1_a),
    .b      (s1_b),
    .prod_c (prod_c)
  );

  // S1 operand capture and S2 product register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s2_v    <= 1'b0;
      s2_prod <= '0;
    end else begin
      s1_v <= accept_c;
      if (accept_c) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
      s2_v <= s1_v;
      if (s1_v) s2_prod <= prod_c;
    end
  end

  // S3 accumulator with sticky wrap flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_c) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (s2_v) begin
      acc <= sum_c[ACC_W-1:0];
      ovf <= ovf | sum_c[ACC_W];
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule
